// File: rtl/blink_pkg.sv
// Shared constants and FSM encoding for the Blink word-serial I/O controller.
package blink_pkg;
    localparam int BLINK_N         = 64;
    localparam int BLINK_TWEAK_LEN = 128;
    localparam int BLINK_ROUNDS    = 14;
    localparam int BLINK_KEY_W     = 448;
    localparam int BLINK_WORD_W    = 32;

    localparam int KEY_WORDS   = 14;
    localparam int TWEAK_WORDS = 4;
    localparam int PT_WORDS    = 2;
    localparam int BLK_WORDS   = 20;

    typedef enum logic [1:0] {
        BLINK_LOAD = 2'd0,
        BLINK_RUN  = 2'd1,
        BLINK_OUT  = 2'd2
    } blink_state_e;
endpackage

// File: rtl/blink_word_loader.sv
// Word counter and slot-decoded write enables that assemble k0/t/p from 32-bit words.
// BLINK_KEY_RETAIN_EN adds key_req and the retained-key skip of the 14 key slots.
module blink_word_loader
    import blink_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr,
    input  logic [BLINK_WORD_W-1:0]    data,
`ifdef BLINK_KEY_RETAIN_EN
    input  logic                       key_req,
`endif
    output logic                       first,
    output logic                       last,
    output logic [BLINK_KEY_W-1:0]     k0,
    output logic [BLINK_TWEAK_LEN-1:0] t,
    output logic [BLINK_N-1:0]         p
);
    logic [4:0]              wc;
    logic [4:0]              slot;
    logic                    skip_key;
    logic [BLK_WORDS-1:0]    we;
    logic [BLINK_WORD_W-1:0] key_w [KEY_WORDS];
    logic [BLINK_WORD_W-1:0] tw_w  [TWEAK_WORDS];
    logic [BLINK_WORD_W-1:0] pt_w  [PT_WORDS];

`ifdef BLINK_KEY_RETAIN_EN
    logic key_valid;

    // A key-less request before any key was ever loaded still loads a key.
    assign skip_key = ~key_req & key_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            key_valid <= 1'b0;
        else if (we[KEY_WORDS-1])
            key_valid <= 1'b1;
    end
`else
    assign skip_key = 1'b0;
`endif

    assign first = (wc == 5'd0);
    assign slot  = (first && skip_key) ? 5'(KEY_WORDS) : wc;
    assign last  = wr && (slot == 5'(BLK_WORDS - 1));
    assign we    = wr ? (BLK_WORDS'(1) << slot) : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            wc <= 5'd0;
        else if (wr)
            wc <= last ? 5'd0 : slot + 5'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < KEY_WORDS; i++)   key_w[i] <= '0;
            for (int i = 0; i < TWEAK_WORDS; i++) tw_w[i]  <= '0;
            for (int i = 0; i < PT_WORDS; i++)    pt_w[i]  <= '0;
        end else begin
            for (int i = 0; i < KEY_WORDS; i++)
                if (we[i]) key_w[i] <= data;
            for (int i = 0; i < TWEAK_WORDS; i++)
                if (we[KEY_WORDS + i]) tw_w[i] <= data;
            for (int i = 0; i < PT_WORDS; i++)
                if (we[KEY_WORDS + TWEAK_WORDS + i]) pt_w[i] <= data;
        end
    end

    // Least-significant word first within each field.
    for (genvar g = 0; g < KEY_WORDS; g++) begin : g_k0
        assign k0[g*BLINK_WORD_W +: BLINK_WORD_W] = key_w[g];
    end
    for (genvar g = 0; g < TWEAK_WORDS; g++) begin : g_t
        assign t[g*BLINK_WORD_W +: BLINK_WORD_W] = tw_w[g];
    end
    for (genvar g = 0; g < PT_WORDS; g++) begin : g_p
        assign p[g*BLINK_WORD_W +: BLINK_WORD_W] = pt_w[g];
    end
endmodule

// File: rtl/blink_io_ctrl.sv
// Word-serial front/back end for the Blink_64_128 core: load words, start core, return result.
// Optional BLINK_KEY_RETAIN_EN adds s_key for 6-word blocks reusing the retained key.
module blink_io_ctrl
    import blink_pkg::*;
#(
    parameter int LAT = 14
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       s_valid,
    output logic                       s_ready,
    input  logic [BLINK_WORD_W-1:0]    s_data,
    input  logic                       s_enc,
`ifdef BLINK_KEY_RETAIN_EN
    input  logic                       s_key,
`endif
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [BLINK_N-1:0]         m_data,
    output logic                       enc,
    output logic [BLINK_KEY_W-1:0]     k0,
    output logic [BLINK_TWEAK_LEN-1:0] t,
    output logic [BLINK_N-1:0]         p,
    output logic                       c_start,
    input  logic [BLINK_N-1:0]         c,
    output logic                       busy
);
    localparam int CNT_W = $clog2(LAT + 1);
    localparam logic [1:0] ST_LOAD = 2'(BLINK_LOAD);
    localparam logic [1:0] ST_RUN  = 2'(BLINK_RUN);
    localparam logic [1:0] ST_OUT  = 2'(BLINK_OUT);

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic             hs;
    logic             first;
    logic             last;

    // Stream handshakes: a transfer happens on a rising edge where valid & ready are both high;
    // ready/valid here come from registered state only, never from the partner's signal.
    assign s_ready = (state == ST_LOAD);
    assign m_valid = (state == ST_OUT);
    assign busy    = (state == ST_RUN) || (state == ST_OUT);
    assign hs      = s_valid & s_ready;

    blink_word_loader u_loader (
        .clk     (clk),
        .rst     (rst),
        .wr      (hs),
        .data    (s_data),
`ifdef BLINK_KEY_RETAIN_EN
        .key_req (s_key),
`endif
        .first   (first),
        .last    (last),
        .k0      (k0),
        .t       (t),
        .p       (p)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_LOAD;
            cnt     <= '0;
            c_start <= 1'b0;
            m_data  <= '0;
            enc     <= 1'b0;
        end else begin
            c_start <= 1'b0;
            case (state)
                ST_LOAD: begin
                    if (hs && first)
                        enc <= s_enc;
                    if (last) begin
                        cnt     <= CNT_W'(LAT);
                        c_start <= 1'b1;
                        state   <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    // cnt reaches zero on edge E0+LAT, so C is sampled on edge E0+LAT+1.
                    if (cnt == '0) begin
                        m_data <= c;
                        state  <= ST_OUT;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_OUT: begin
                    if (m_ready)
                        state <= ST_LOAD;
                end
                default: state <= ST_LOAD;
            endcase
        end
    end
endmodule
